// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency single-port word memory with a CPU handshake.
// Optional debug read port enabled by defining DMEM_DEBUG_PORT_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    input  logic              d_re,
`ifdef DMEM_DEBUG_PORT_EN
    input  logic [3:0]        select_y,
    output logic [DATA_W-1:0] y,
`endif
    output logic [DATA_W-1:0] d_datain,
    output logic              d_ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic                we_q, we_nxt;
    logic                re_q, re_nxt;
    logic                ready_nxt;
    logic [DATA_W-1:0]   datain_nxt;

    logic                enter_resp_c;
    logic [ADDR_W-1:0]   acc_addr_c;
    logic [DATA_W-1:0]   acc_data_c;
    logic                acc_we_c;
    logic                acc_re_c;
    logic                mem_wr_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    // State, request latch and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            d_ready  <= 1'b0;
            d_datain <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            addr_q   <= addr_nxt;
            data_q   <= data_nxt;
            we_q     <= we_nxt;
            re_q     <= re_nxt;
            d_ready  <= ready_nxt;
            d_datain <= datain_nxt;
        end
    end

    // Next-state and access decode; with zero wait states the access uses the live inputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_nxt     = addr_q;
        data_nxt     = data_q;
        we_nxt       = we_q;
        re_nxt       = re_q;
        ready_nxt    = 1'b0;
        datain_nxt   = d_datain;
        enter_resp_c = 1'b0;
        acc_addr_c   = addr_q;
        acc_data_c   = data_q;
        acc_we_c     = we_q;
        acc_re_c     = re_q;
        mem_wr_c     = 1'b0;

        case (state)
            IDLE: begin
                if (enable && (d_re || d_we)) begin
                    addr_nxt = d_addr;
                    data_nxt = d_dataout;
                    we_nxt   = d_we;
                    re_nxt   = d_re;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt    = RESP;
                        enter_resp_c = 1'b1;
                        acc_addr_c   = d_addr;
                        acc_data_c   = d_dataout;
                        acc_we_c     = d_we;
                        acc_re_c     = d_re;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt    = RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (enter_resp_c) begin
            ready_nxt = 1'b1;
            if (acc_we_c) begin
                mem_wr_c = 1'b1;
                if (acc_re_c) begin
                    datain_nxt = acc_data_c;
                end
            end else begin
                datain_nxt = mem[acc_addr_c];
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_wr_c) begin
            mem[acc_addr_c] <= acc_data_c;
        end
    end

`ifdef DMEM_DEBUG_PORT_EN
    assign y = mem[ADDR_W'(select_y)];
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned LAT         = WAIT_CYCLES + 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              enable    = 1'b0;
    logic [ADDR_W-1:0] d_addr    = '0;
    logic [DATA_W-1:0] d_dataout = '0;
    logic              d_we      = 1'b0;
    logic              d_re      = 1'b0;
    logic [DATA_W-1:0] d_datain;
    logic              d_ready;
`ifdef DMEM_DEBUG_PORT_EN
    logic [3:0]        select_y  = '0;
    logic [DATA_W-1:0] y;
`endif

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clock     (clk),
        .reset     (rst_n),
        .enable    (enable),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we),
        .d_re      (d_re),
`ifdef DMEM_DEBUG_PORT_EN
        .select_y  (select_y),
        .y         (y),
`endif
        .d_datain  (d_datain),
        .d_ready   (d_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] mdl_mem [1 << ADDR_W];
    logic [DATA_W-1:0] mdl_dout = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access: hold the request until d_ready, then check latency, data and pulse width
    task automatic access(input logic we, input logic re, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input bit drop_en);
        int lat;
        bit done;
        enable    = 1'b1;
        d_we      = we;
        d_re      = re;
        d_addr    = addr;
        d_dataout = data;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (drop_en && lat == 1) enable = 1'b0;
            if (d_ready) done = 1'b1;
        end
        d_we = 1'b0;
        d_re = 1'b0;
        check("ready_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), 32'(LAT));
        if (we) begin
            mdl_mem[addr] = data;
            if (re) mdl_dout = data;
        end else begin
            mdl_dout = mdl_mem[addr];
        end
        check("d_datain", 32'(d_datain), 32'(mdl_dout));
        tick();
        check("ready_one_cycle", 32'(d_ready), 32'd0);
        enable = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pulses;
        int op;
        logic [ADDR_W-1:0] a;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(d_ready), 32'd0);
        check("rst_datain", 32'(d_datain), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        mdl_dout = '0;

        for (int i = 0; i <= 32; i++) begin
            access(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom), 1'b0);
        end

        access(1'b1, 1'b0, 8'h05, 16'hBEEF, 1'b0);
`ifdef DMEM_DEBUG_PORT_EN
        select_y = 4'd5;
        #1;
        check("debug_y", 32'(y), 32'h0000BEEF);
`endif

        access(1'b0, 1'b1, 8'h05, 16'h0000, 1'b0);
        repeat (10) tick();
        check("hold_datain", 32'(d_datain), 32'h0000BEEF);

        access(1'b1, 1'b1, 8'h10, 16'h1234, 1'b0);
        check("simul_datain", 32'(d_datain), 32'h00001234);
        access(1'b0, 1'b1, 8'h10, 16'h0000, 1'b0);
        check("reload_10", 32'(d_datain), 32'h00001234);

        enable = 1'b0;
        d_re   = 1'b1;
        d_addr = 8'h03;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("enable_block", 32'(d_ready), 32'd0);
        end
        d_re   = 1'b0;
        enable = 1'b1;
        access(1'b0, 1'b1, 8'h07, 16'h0000, 1'b1);

        // Request held continuously: one completion per WAIT_CYCLES+2 cycles
        d_re   = 1'b1;
        d_addr = 8'h10;
        pulses = 0;
        for (int i = 0; i < int'(4 * (WAIT_CYCLES + 2)); i++) begin
            tick();
            if (d_ready) begin
                pulses++;
                check("held_datain", 32'(d_datain), 32'(mdl_mem[8'h10]));
            end
        end
        d_re = 1'b0;
        mdl_dout = mdl_mem[8'h10];
        check("held_pulses", 32'(pulses), 32'd4);
        tick();

        for (int i = 0; i < 80; i++) begin
            a  = ADDR_W'($urandom_range(0, 31));
            op = int'($urandom_range(0, 2));
            access(op != 0, op != 1, a, DATA_W'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("idle_ready", 32'(d_ready), 32'd0);
                check("idle_datain", 32'(d_datain), 32'(mdl_dout));
            end
        end

        // Reset during WAIT aborts the store and clears outputs immediately
        access(1'b1, 1'b0, 8'h20, 16'h5A5A, 1'b0);
        access(1'b0, 1'b1, 8'h20, 16'h0000, 1'b0);
        d_we      = 1'b1;
        d_addr    = 8'h20;
        d_dataout = 16'hAAAA;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(d_ready), 32'd0);
        check("abort_datain", 32'(d_datain), 32'd0);
        d_we = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        mdl_dout = '0;
        tick();
        check("post_rst_datain", 32'(d_datain), 32'd0);
        access(1'b0, 1'b1, 8'h20, 16'h0000, 1'b0);
        check("abort_mem", 32'(d_datain), 32'h00005A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 8, data-memory address width (memory depth 2^ADDR_W words).
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, wait states inserted before the response (0..15).

REQ-002 The block SHALL have these ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high permits acceptance of new requests.
- d_addr  in  ADDR_W  CPU data address.
- d_dataout  in  DATA_W  CPU store data.
- d_we  in  1  store request.
- d_re  in  1  load request.
- d_datain  out  DATA_W  load data returned to CPU (registered).
- d_ready  out  1  one-cycle completion strobe (registered).

REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, WAIT and RESP, held in a storage array of 2^ADDR_W x DATA_W.
REQ-005 In IDLE with enable=1 and (d_re|d_we)=1 at a rising edge, it SHALL latch d_addr, d_dataout and d_we, then go to WAIT with cnt=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
REQ-006 In WAIT it SHALL decrement cnt each edge and go to RESP on the edge where cnt==0.
REQ-007 On the edge entering RESP:
- a store SHALL commit latched data to mem[latched addr];
- a load SHALL register mem[latched addr] into d_datain.
REQ-008 d_ready SHALL be 1 for exactly the one cycle spent in RESP; RESP SHALL always return to IDLE on the next edge.
REQ-009 Timing: a request sampled at edge k SHALL produce d_ready=1 in the cycle after edge k+WAIT_CYCLES; peak throughput is one access per WAIT_CYCLES+2 cycles.
REQ-010 With d_re=d_we=1 simultaneously, the access SHALL be a store, and d_datain SHALL take the stored value at RESP.
REQ-011 Request inputs SHALL be ignored in WAIT and RESP; the CPU holds its request until d_ready and it is not re-accepted in RESP.
REQ-012 Deasserting enable SHALL only block acceptance in IDLE; an in-flight access SHALL complete normally.
REQ-013 d_datain SHALL hold its last loaded value through stores and idle cycles.
REQ-014 A store SHALL be visible to any load accepted after its d_ready; there is no forwarding.

Reset
REQ-015 While reset=0, the block SHALL force state=IDLE, cnt=0, d_ready=0 and d_datain=0 immediately, without waiting for a clock edge.
REQ-016 Reset asserted before the RESP entry edge SHALL abort the access, leaving memory unwritten; memory contents are not cleared by reset.

Configuration
REQ-017 With macro DMEM_DEBUG_PORT_EN defined, the block SHALL add input select_y[3:0] and output y[DATA_W-1:0]:
- y = mem[select_y] combinationally;
- the port is independent of the FSM and of reset;
- without the macro, neither port exists and behaviour is otherwise identical.

Verification
REQ-018 Store, WAIT_CYCLES=2: d_we=1, d_addr=8'h05, d_dataout=16'hBEEF sampled at edge 0 -> d_ready=1 after edge 2 for one cycle only; with debug port, select_y=5 gives y=16'hBEEF.
REQ-019 Load after store: d_re=1, d_addr=8'h05 -> d_datain=16'hBEEF with d_ready after edge 2; d_datain still 16'hBEEF 10 cycles later.
REQ-020 Simultaneous request: d_re=d_we=1, d_addr=8'h10, d_dataout=16'h1234 -> store; d_datain=16'h1234 at d_ready; a subsequent load of 8'h10 returns 16'h1234.
REQ-021 Enable gating: enable=0 with d_re held for 5 cycles -> d_ready stays 0; enable drops to 0 during WAIT -> the access still completes with d_ready=1.
REQ-022 Reset mid-store: store 16'hAAAA to 8'h20 begins, then reset=0 during WAIT -> d_ready=0 and d_datain=0 at once; a later load of 8'h20 returns the prior contents, not 16'hAAAA.
REQ-023 WAIT_CYCLES=0 build: back-to-back loads held high -> d_ready pulses every second cycle, with one cycle of latency each.
